// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: mux select codes, $zero address, stage record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int REG_W = 5;

    typedef logic [1:0] sel_t;

    // ALU operand mux selects; 2'b11 is never produced.
    localparam sel_t SEL_RF    = 2'b00;
    localparam sel_t SEL_EXMEM = 2'b01;
    localparam sel_t SEL_MEMWB = 2'b10;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Destination-side view of one pipeline stage.
    typedef struct packed {
        logic             valid;
        logic             wreg;
        logic [REG_W-1:0] dst;
        logic             is_load;
    } stage_rec_t;

    // A stage only produces a forwardable value if it really writes a
    // register other than $zero.
    function automatic logic is_writer(input logic             valid,
                                       input logic             wreg,
                                       input logic [REG_W-1:0] dst);
        return valid & wreg & (dst != REG_ZERO);
    endfunction

endpackage

// File: rtl/fwd_stall_unit_if.sv
// ID-stage hazard query bundle between the pipeline and the forwarding/stall unit.
// Latency: n/a (wires only).
// Backpressure: stall flows back to the pipeline; no other handshake.
// Ports: id_* describe the instruction in ID, flush kills it; the unit returns
// the two operand select codes, the stall request and the stall counter.
interface fwd_stall_unit_if
    import cpu_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wreg;
    logic [RA_W-1:0]  id_wdst;
    logic             id_is_load;
    logic             flush;
    sel_t             fwd_a_sel;
    sel_t             fwd_b_sel;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side.
    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_wdst, id_is_load, flush,
        input  fwd_a_sel, fwd_b_sel, stall, stall_cnt
    );

    // Hazard unit side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_wdst, id_is_load, flush,
        output fwd_a_sel, fwd_b_sel, stall, stall_cnt
    );

endinterface

// File: rtl/fwd_sel_cmp.sv
// Per-operand forwarding comparator: picks RF, EX/MEM or MEM/WB for one EX source.
// Latency: purely combinational.
// Backpressure: none.
// Ports: ex_valid/ex_use/ex_src describe the EX operand; mem_*/wb_* the older
// producers (mem_wr/wb_wr already include the $zero and valid checks); sel out.
module fwd_sel_cmp
    import cpu_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            ex_valid,
    input  logic            ex_use,
    input  logic [RA_W-1:0] ex_src,
    input  logic            mem_wr,
    input  logic [RA_W-1:0] mem_dst,
    input  logic            mem_is_load,
    input  logic            wb_wr,
    input  logic [RA_W-1:0] wb_dst,
    output sel_t            sel
);

    always_comb begin
        sel = SEL_RF;
        if (ex_valid && ex_use) begin
            // MEM is younger than WB, so it wins. Load data is not yet
            // available at the EX/MEM latch, hence never forwarded from there.
            if (mem_wr && (mem_dst == ex_src) && !mem_is_load) begin
                sel = SEL_EXMEM;
            end else if (wb_wr && (wb_dst == ex_src)) begin
                sel = SEL_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_stall_unit.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Latency: stall is combinational from ID inputs; selects are combinational from registered EX/MEM/WB shadows.
// Backpressure: stall freezes PC and IF/ID for one cycle per load-use hazard and bubbles EX.
// Ports: clk, rst (async, active-high); bus (slave modport) carries ID query,
// flush, fwd_a_sel/fwd_b_sel, stall and the saturating stall_cnt.
module fwd_stall_unit
    import cpu_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    fwd_stall_unit_if.slave  bus
);

    // EX carries source info as well, since forwarding serves the EX instruction.
    stage_rec_t       ex_q;
    logic [RA_W-1:0]  ex_rs_q;
    logic [RA_W-1:0]  ex_rt_q;
    logic             ex_use_rs_q;
    logic             ex_use_rt_q;

    stage_rec_t       mem_q;

    // WB needs no is_load: nothing downstream cares.
    logic             wb_valid_q;
    logic             wb_wreg_q;
    logic [RA_W-1:0]  wb_dst_q;

    logic [CNT_W-1:0] stall_cnt_q;

    logic             ex_wr;
    logic             mem_wr;
    logic             wb_wr;
    logic             stall_w;
    logic             ex_load;

    assign ex_wr  = is_writer(ex_q.valid, ex_q.wreg, ex_q.dst);
    assign mem_wr = is_writer(mem_q.valid, mem_q.wreg, mem_q.dst);
    assign wb_wr  = is_writer(wb_valid_q, wb_wreg_q, wb_dst_q);

    // Load in EX feeding the ID instruction: its data only exists after MEM,
    // so ID waits one cycle. A flushed ID instruction needs no data.
    assign stall_w = bus.id_valid & ~bus.flush & ex_wr & ex_q.is_load &
                     ((bus.id_use_rs & (bus.id_rs == ex_q.dst)) |
                      (bus.id_use_rt & (bus.id_rt == ex_q.dst)));

    assign ex_load = bus.id_valid & ~bus.flush & ~stall_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_use_rs_q <= 1'b0;
            ex_use_rt_q <= 1'b0;
            mem_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_wreg_q   <= 1'b0;
            wb_dst_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            // Bubbles are fully zeroed so no stale field can ever match.
            if (ex_load) begin
                ex_q.valid   <= 1'b1;
                ex_q.wreg    <= bus.id_wreg;
                ex_q.dst     <= bus.id_wdst;
                ex_q.is_load <= bus.id_is_load;
                ex_rs_q      <= bus.id_rs;
                ex_rt_q      <= bus.id_rt;
                ex_use_rs_q  <= bus.id_use_rs;
                ex_use_rt_q  <= bus.id_use_rt;
            end else begin
                ex_q        <= '0;
                ex_rs_q     <= '0;
                ex_rt_q     <= '0;
                ex_use_rs_q <= 1'b0;
                ex_use_rt_q <= 1'b0;
            end

            mem_q      <= ex_q;
            wb_valid_q <= mem_q.valid;
            wb_wreg_q  <= mem_q.wreg;
            wb_dst_q   <= mem_q.dst;

            if (stall_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    fwd_sel_cmp #(.RA_W(RA_W)) u_cmp_a (
        .ex_valid    (ex_q.valid),
        .ex_use      (ex_use_rs_q),
        .ex_src      (ex_rs_q),
        .mem_wr      (mem_wr),
        .mem_dst     (mem_q.dst),
        .mem_is_load (mem_q.is_load),
        .wb_wr       (wb_wr),
        .wb_dst      (wb_dst_q),
        .sel         (bus.fwd_a_sel)
    );

    fwd_sel_cmp #(.RA_W(RA_W)) u_cmp_b (
        .ex_valid    (ex_q.valid),
        .ex_use      (ex_use_rt_q),
        .ex_src      (ex_rt_q),
        .mem_wr      (mem_wr),
        .mem_dst     (mem_q.dst),
        .mem_is_load (mem_q.is_load),
        .wb_wr       (wb_wr),
        .wb_dst      (wb_dst_q),
        .sel         (bus.fwd_b_sel)
    );

    assign bus.stall     = stall_w;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_stall_unit.sv
// Directed bench for fwd_stall_unit: drives ID instruction sequences and checks
// selects, stall and stall counter against hand-derived values.
// Inputs change 1 ns after the rising edge; outputs are checked before the next edge.
module tb_fwd_stall_unit;
    import cpu_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fwd_stall_unit_if #(.RA_W(5), .CNT_W(32)) bus ();

    fwd_stall_unit #(.RA_W(5), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic id_ins(input logic [4:0] rs, input logic [4:0] rt,
                          input logic ur, input logic ut, input logic wr,
                          input logic [4:0] wd, input logic ld);
        bus.id_valid   = 1'b1;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_use_rs  = ur;
        bus.id_use_rt  = ut;
        bus.id_wreg    = wr;
        bus.id_wdst    = wd;
        bus.id_is_load = ld;
        bus.flush      = 1'b0;
    endtask

    task automatic id_nop();
        bus.id_valid   = 1'b0;
        bus.id_rs      = '0;
        bus.id_rt      = '0;
        bus.id_use_rs  = 1'b0;
        bus.id_use_rt  = 1'b0;
        bus.id_wreg    = 1'b0;
        bus.id_wdst    = '0;
        bus.id_is_load = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        id_nop();

        // Reset state
        @(negedge clk);
        chk("rst_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_RF));
        chk("rst_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_RF));
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_cnt",   bus.stall_cnt, 32'd0);
        rst = 1'b0;

        // Populate pipeline, then reset mid-stream.
        id_ins(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1);   // lw $1,0($3)
        cyc();
        id_ins(5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);   // add $5,$1,$1
        @(negedge clk);
        chk("pre_stall", 32'(bus.stall), 32'd1);
        cyc();                                               // bubble into EX, add held
        cyc();                                               // add in EX, lw in WB
        chk("pre_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_MEMWB));
        chk("pre_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_MEMWB));
        chk("pre_cnt",   bus.stall_cnt, 32'd1);
        id_nop();
        #2 rst = 1'b1;
        #1;
        chk("midrst_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_RF));
        chk("midrst_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_RF));
        chk("midrst_stall", 32'(bus.stall), 32'd0);
        chk("midrst_cnt",   bus.stall_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        id_ins(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);   // add $6,$5,$5
        cyc();
        chk("postrst_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_RF));
        chk("postrst_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_RF));

        // EX/MEM forward
        id_ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);   // add $3,$1,$2
        cyc();
        id_ins(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);   // sub $4,$3,$5
        @(negedge clk);
        chk("exmem_stall", 32'(bus.stall), 32'd0);
        cyc();
        chk("exmem_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_EXMEM));
        chk("exmem_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_RF));

        // MEM/WB forward across a nop
        id_ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);   // add $3,$1,$2
        cyc();
        id_nop();
        cyc();
        id_ins(5'd7, 5'd3, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);   // or $6,$7,$3
        cyc();
        chk("memwb_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_RF));
        chk("memwb_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_MEMWB));

        // MEM beats WB
        id_ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);   // add $3
        cyc();
        id_ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);   // add $3
        cyc();
        id_ins(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);   // and $8,$3,$3
        cyc();
        chk("prio_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_EXMEM));
        chk("prio_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_EXMEM));

        // Load-use: one stall cycle, then MEM/WB forward
        id_ins(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1);   // lw $2,0($1)
        cyc();
        id_ins(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);   // add $4,$2,$2
        @(negedge clk);
        chk("lu_stall",   32'(bus.stall), 32'd1);
        chk("lu_cnt0",    bus.stall_cnt, 32'd0);
        cyc();
        chk("lu_cnt1",    bus.stall_cnt, 32'd1);
        @(negedge clk);
        chk("lu_stall_end", 32'(bus.stall), 32'd0);
        cyc();
        id_nop();
        chk("lu_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_MEMWB));
        chk("lu_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_MEMWB));
        chk("lu_cnt_hold", bus.stall_cnt, 32'd1);

        // $zero is never forwarded
        id_ins(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);   // addi $0,$0,5
        cyc();
        id_ins(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);   // add $9,$0,$0
        cyc();
        chk("zero_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_RF));
        chk("zero_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_RF));

        // Store does not write a register
        id_ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd2, 1'b0);   // sw $2,0($1)
        cyc();
        id_ins(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0);  // add $10,$2,$2
        cyc();
        chk("store_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_RF));
        chk("store_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_RF));

        // Flush overrides load-use stall and leaves a bubble in EX
        id_ins(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1);   // lw $2,0($1)
        cyc();
        id_ins(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);   // add $4,$2,$2
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", 32'(bus.stall), 32'd0);
        cyc();
        id_nop();
        chk("flush_a_sel", 32'(bus.fwd_a_sel), 32'(SEL_RF));
        chk("flush_b_sel", 32'(bus.fwd_b_sel), 32'(SEL_RF));
        chk("flush_cnt",   bus.stall_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
